img_frame_sequencer: RTL

Frame sequencer that drives the grey-level processing cores (e.g. `region_bin_auto_proc`) with a well-formed `vsync`/`href`/`gray` stream. It pulls pixels from an upstream valid/ready source, such as a frame-buffer reader, and inserts the programmed vertical pre/post porch and horizontal blanking. It also flags source underflow mid-line, so the processing pipeline and its bench see exactly the timing the cores are verified against.

---
 rtl/img_seq_pkg.sv | 24 ++
 rtl/img_frame_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/img_seq_pkg.sv
// Shared state encoding, pixel width and sizing helper for the image frame sequencer.
package img_seq_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    VPRE,
    LINE,
    HBLANK,
    VPOST,
    GAP
  } img_seq_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/img_frame_sequencer.sv
// Generates vsync/href/gray frames from a valid/ready pixel source with programmed porches.
// Define IMG_SEQ_CONT_EN for continuous mode (GAP state, start sampled as a level between frames).
module img_frame_sequencer
  import img_seq_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 10,
  parameter int V_PRE     = 5,
  parameter int V_POST    = 5,
  parameter int FRAME_GAP = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             src_valid,
  input  logic [PIX_W-1:0] src_data,
  output logic             src_ready,
  output logic             per_img_vsync,
  output logic             per_img_href,
  output logic [PIX_W-1:0] per_img_gray,
  output logic             busy,
  output logic             frame_done,
  output logic             underflow
);

  localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  // VPOST counts one past V_POST so the vsync fall lands after V_POST href-low cycles.
  localparam int CNT_W = $clog2(max4(H_BLANK, V_PRE, V_POST, FRAME_GAP) + 1);

  img_seq_state_t   state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] cnt;
  logic             hs;

  // NOTE: plain continuous assigns decode state directly; no always_comb, so no latch risk.
  assign src_ready = (state == LINE);
  assign busy      = (state != IDLE);
  assign hs        = src_valid & src_ready;

  // NOTE: every register below is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; nothing here is a memory, so every register is cleared.
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      cnt           <= '0;
      per_img_vsync <= 1'b0;
      per_img_href  <= 1'b0;
      per_img_gray  <= '0;
      frame_done    <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      per_img_href <= 1'b0;
      case (state)
        IDLE: begin
          per_img_vsync <= 1'b0;
          if (start) begin
            state     <= VPRE;
            underflow <= 1'b0;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
          end
        end
        VPRE: begin
          per_img_vsync <= 1'b1;
          if (cnt == CNT_W'(V_PRE - 1)) begin
            cnt   <= '0;
            state <= LINE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LINE: begin
          per_img_vsync <= 1'b1;
          if (hs) begin
            per_img_href <= 1'b1;
            per_img_gray <= src_data;
            if (col == COL_W'(IMG_HDISP - 1)) begin
              col <= '0;
              if (row == ROW_W'(IMG_VDISP - 1)) begin
                row   <= '0;
                state <= VPOST;
              end else begin
                row   <= row + ROW_W'(1);
                state <= HBLANK;
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end else if (col != '0) begin
            // Waiting before a line's first pixel is legal; a stall inside a line is not.
            underflow <= 1'b1;
          end
        end
        HBLANK: begin
          per_img_vsync <= 1'b1;
          if (cnt == CNT_W'(H_BLANK - 1)) begin
            cnt   <= '0;
            state <= LINE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        VPOST: begin
          if (cnt == CNT_W'(V_POST)) begin
            cnt           <= '0;
            per_img_vsync <= 1'b0;
            frame_done    <= 1'b1;
`ifdef IMG_SEQ_CONT_EN
            state         <= GAP;
`else
            state         <= IDLE;
`endif
          end else begin
            per_img_vsync <= 1'b1;
            cnt           <= cnt + CNT_W'(1);
          end
        end
`ifdef IMG_SEQ_CONT_EN
        GAP: begin
          per_img_vsync <= 1'b0;
          if (cnt == CNT_W'(FRAME_GAP - 1)) begin
            cnt <= '0;
            if (start) begin
              // vsync rises on the exit edge, so VPRE is entered one count in.
              per_img_vsync <= 1'b1;
              if (V_PRE > 1) begin
                state <= VPRE;
                cnt   <= CNT_W'(1);
              end else begin
                state <= LINE;
              end
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          per_img_vsync <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
